// File: rtl/tdm_demux4.sv
// tdm_demux4: receive end of the 4-channel TDM link.
// Collects channel words 0..3 from a serial beat stream (channel 0 marked by
// in_sof) and presents them as one registered parallel frame on y0..y3.
// Framing violations are flagged with a one-cycle pulse and counted in a
// saturating counter.
module tdm_demux4 #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sof,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [1:0]       ch_idx,
    output logic             frame_err,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] c0;
    logic [WIDTH-1:0] c1;
    logic [WIDTH-1:0] c2;
    logic             accept;
    logic             last_beat;

    // Only the completing beat can stall, and only while an unread frame
    // still occupies the output registers.
    always_comb begin
        last_beat = (ch_idx == 2'd3);
        in_ready  = !reset && !(last_beat && out_valid && !out_ready);
        accept    = in_valid && in_ready;
    end

    // Framing FSM, capture registers, output frame and error counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ch_idx    <= '0;
            c0        <= '0;
            c1        <= '0;
            c2        <= '0;
            y0        <= '0;
            y1        <= '0;
            y2        <= '0;
            y3        <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            err_count <= '0;
        end else begin
            frame_err <= 1'b0;

            // Consumer handshake; a completing frame below overrides this.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (accept) begin
                if (state == IDLE) begin
                    if (in_sof) begin
                        c0     <= in_data;
                        ch_idx <= 2'd1;
                        state  <= COLLECT;
                    end else begin
                        frame_err <= 1'b1;
                        if (err_count != '1) begin
                            err_count <= err_count + 1'b1;
                        end
                    end
                end else begin
                    if (in_sof) begin
                        // Unexpected start of frame: drop partial, restart.
                        frame_err <= 1'b1;
                        if (err_count != '1) begin
                            err_count <= err_count + 1'b1;
                        end
                        c0     <= in_data;
                        ch_idx <= 2'd1;
                    end else begin
                        case (ch_idx)
                            2'd1: begin
                                c1     <= in_data;
                                ch_idx <= 2'd2;
                            end
                            2'd2: begin
                                c2     <= in_data;
                                ch_idx <= 2'd3;
                            end
                            2'd3: begin
                                y0        <= c0;
                                y1        <= c1;
                                y2        <= c2;
                                y3        <= in_data;
                                out_valid <= 1'b1;
                                ch_idx    <= 2'd0;
                                state     <= IDLE;
                            end
                            default: begin
                                ch_idx <= 2'd0;
                                state  <= IDLE;
                            end
                        endcase
                    end
                end
            end
        end
    end

endmodule
